// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } seq_state_e;

    localparam logic [31:0] PC_STEP       = 32'd4;
    localparam logic [31:0] PC_RESET_ADDR = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_ADDR   = 32'h0000_0180;

    // Fetch addresses are always word aligned; low bits of any target are dropped.
    function automatic logic [31:0] align_target(input logic [31:0] t);
        return {t[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle: redirect requests, instruction memory handshake and
// the fetched-instruction outputs. With PC_SEQ_EXC_EN defined an exception
// redirect input (exc) is added.
interface pc_sequencer_if;

`ifdef PC_SEQ_EXC_EN
    logic        exc;
`endif
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] pc;

    // Sequencer side
    modport master (
`ifdef PC_SEQ_EXC_EN
        input  exc,
`endif
        input  stall,
        input  br_taken,
        input  br_target,
        input  jmp,
        input  jmp_target,
        input  imem_ack,
        output imem_req,
        output imem_addr,
        output if_valid,
        output if_pc,
        output pc
    );

    // Memory / pipeline side
    modport slave (
`ifdef PC_SEQ_EXC_EN
        output exc,
`endif
        output stall,
        output br_taken,
        output br_target,
        output jmp,
        output jmp_target,
        output imem_ack,
        input  imem_req,
        input  imem_addr,
        input  if_valid,
        input  if_pc,
        input  pc
    );

endinterface

// File: rtl/pc_sequencer_pc_reg.sv
// Program counter register: async active-low clear to RESET_ADDR, load enable.
module pc_reg #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);

    logic [31:0] pc_q;

    // Load a new pc only when the sequencer commits a step or redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_ADDR;
        end else if (en_i) begin
            pc_q <= d_i;
        end
    end

    assign q_o = pc_q;

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: issues word fetches, presents returned
// instructions downstream, honours stalls and branch/jump redirects.
// Optional feature macro: PC_SEQ_EXC_EN adds an exception redirect to
// EXC_ADDR at top priority.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | one cycle after reset release, no request issued
// ST_REQ  | imem_req high at pc, waiting for imem_ack
// ST_HOLD | instruction presented, downstream stalled, no request
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = PC_RESET_ADDR,
    parameter logic [31:0] EXC_ADDR   = PC_EXC_ADDR
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.master bus
);

    seq_state_e  state_q, state_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        pc_en;
    logic [31:0] pc_d, pc_q;
    logic        imem_req;
    logic        redir_live;
    logic [31:0] redir_tgt;

`ifndef PC_SEQ_EXC_EN
    logic unused_exc_addr;
    assign unused_exc_addr = ^EXC_ADDR;
`endif

    pc_reg #(
        .RESET_ADDR (RESET_ADDR)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (reset),
        .en_i  (pc_en),
        .d_i   (pc_d),
        .q_o   (pc_q)
    );

    // Redirect arbitration; later assignments win, giving exc > br_taken > jmp
    always_comb begin
        redir_live = 1'b0;
        redir_tgt  = '0;
        if (bus.jmp) begin
            redir_live = 1'b1;
            redir_tgt  = align_target(bus.jmp_target);
        end
        if (bus.br_taken) begin
            redir_live = 1'b1;
            redir_tgt  = align_target(bus.br_target);
        end
`ifdef PC_SEQ_EXC_EN
        if (bus.exc) begin
            redir_live = 1'b1;
            redir_tgt  = align_target(EXC_ADDR);
        end
`endif
    end

    // State, pending redirect and presented instruction registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
        end
    end

    // Next-state and fetch control
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        if_valid_d = 1'b0;
        if_pc_d    = if_pc_q;
        pc_en      = 1'b0;
        pc_d       = pc_q + PC_STEP;
        imem_req   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                imem_req = 1'b1;
                if (bus.imem_ack) begin
                    if (redir_live || pend_q) begin
                        // Returned word belongs to the abandoned path
                        pc_en  = 1'b1;
                        pc_d   = redir_live ? redir_tgt : pend_tgt_q;
                        pend_d = 1'b0;
                    end else begin
                        if_valid_d = 1'b1;
                        if_pc_d    = pc_q;
                        if (bus.stall) begin
                            state_d = ST_HOLD;
                        end else begin
                            pc_en = 1'b1;
                        end
                    end
                end else if (redir_live) begin
                    // Address must not move mid-request; apply on ack
                    pend_d     = 1'b1;
                    pend_tgt_d = redir_tgt;
                end
            end
            ST_HOLD: begin
                if (redir_live) begin
                    pc_en   = 1'b1;
                    pc_d    = redir_tgt;
                    state_d = ST_REQ;
                end else if (bus.stall) begin
                    if_valid_d = 1'b1;
                end else begin
                    pc_en   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.imem_req  = imem_req;
    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.pc        = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: expected fetch addresses and delivered
// instructions are queued as stimulus is driven and compared by a monitor.
module tb_pc_sequencer;

    logic clk;
    logic reset;

    pc_sequencer_if bus_if ();

    pc_sequencer #(
        .RESET_ADDR (32'h0000_0000),
        .EXC_ADDR   (32'h0000_0180)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.master)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_req_q[$];
    logic [31:0] exp_out_q[$];
    logic        prev_v;
    logic [31:0] prev_pc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output int waited);
        waited = 0;
        while (!bus_if.imem_req && waited < 20) begin
            tick();
            waited++;
        end
        chk("req_seen", 32'(bus_if.imem_req), 32'd1);
    endtask

    task automatic fetch(input logic [31:0] a, input bit deliver, output int waited);
        wait_req(waited);
        exp_req_q.push_back(a);
        if (deliver) exp_out_q.push_back(a);
        bus_if.imem_ack = 1'b1;
        tick();
        bus_if.imem_ack = 1'b0;
    endtask

    // Ack the pending request at address a together with redirect requests
    task automatic ack_redirect(input logic [31:0] a, input bit b, input bit j, input bit e,
                                input logic [31:0] bt, input logic [31:0] jt);
        int w;
        wait_req(w);
        exp_req_q.push_back(a);
        bus_if.br_taken   = b;
        bus_if.br_target  = bt;
        bus_if.jmp        = j;
        bus_if.jmp_target = jt;
`ifdef PC_SEQ_EXC_EN
        bus_if.exc        = e;
`endif
        if (e) begin end
        bus_if.imem_ack   = 1'b1;
        tick();
        bus_if.imem_ack   = 1'b0;
        bus_if.br_taken   = 1'b0;
        bus_if.jmp        = 1'b0;
`ifdef PC_SEQ_EXC_EN
        bus_if.exc        = 1'b0;
`endif
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},   32'(bus_if.imem_req), 32'd0);
        chk({tag, "_addr"},  bus_if.imem_addr, 32'h0);
        chk({tag, "_valid"}, 32'(bus_if.if_valid), 32'd0);
        chk({tag, "_ifpc"},  bus_if.if_pc, 32'h0);
        chk({tag, "_pc"},    bus_if.pc, 32'h0);
    endtask

    // Scoreboard monitor: fetch addresses at each handshake, and each new
    // presented instruction (rising if_valid or a change of if_pc)
    always @(negedge clk) begin
        if (bus_if.imem_req && bus_if.imem_ack) begin
            if (exp_req_q.size() == 0) chk("req_extra", 32'(exp_req_q.size()), 32'd1);
            else chk("imem_addr", bus_if.imem_addr, exp_req_q.pop_front());
        end
        if (bus_if.if_valid && (!prev_v || bus_if.if_pc != prev_pc)) begin
            if (exp_out_q.size() == 0) chk("out_extra", 32'(exp_out_q.size()), 32'd1);
            else chk("if_pc", bus_if.if_pc, exp_out_q.pop_front());
        end
        prev_v  <= bus_if.if_valid;
        prev_pc <= bus_if.if_pc;
    end

    initial begin
        int w;
        reset             = 1'b0;
        bus_if.stall      = 1'b0;
        bus_if.br_taken   = 1'b0;
        bus_if.br_target  = '0;
        bus_if.jmp        = 1'b0;
        bus_if.jmp_target = '0;
        bus_if.imem_ack   = 1'b0;
`ifdef PC_SEQ_EXC_EN
        bus_if.exc        = 1'b0;
`endif
        repeat (3) tick();
        chk_reset_vals("rst");
        reset = 1'b1;

        // Back-to-back fetches from reset
        fetch(32'h0, 1'b1, w);
        fetch(32'h4, 1'b1, w);
        chk("no_bubble", 32'(w), 32'd0);

        // Stall held for three cycles at ack of 0x8
        wait_req(w);
        exp_req_q.push_back(32'h8);
        exp_out_q.push_back(32'h8);
        bus_if.imem_ack = 1'b1;
        bus_if.stall    = 1'b1;
        tick();
        bus_if.imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) bus_if.stall = 1'b0;
            chk("hold_req",   32'(bus_if.imem_req), 32'd0);
            chk("hold_valid", 32'(bus_if.if_valid), 32'd1);
            chk("hold_ifpc",  bus_if.if_pc, 32'h8);
            tick();
        end
        chk("pc_after_hold", bus_if.pc, 32'hC);
        fetch(32'hC, 1'b1, w);

        // Branch while 0x10 waits for ack; ack two cycles later
        wait_req(w);
        exp_req_q.push_back(32'h10);
        bus_if.br_taken  = 1'b1;
        bus_if.br_target = 32'h100;
        tick();
        bus_if.br_taken  = 1'b0;
        chk("pend_addr1", bus_if.imem_addr, 32'h10);
        tick();
        chk("pend_addr2", bus_if.imem_addr, 32'h10);
        bus_if.imem_ack = 1'b1;
        tick();
        bus_if.imem_ack = 1'b0;
        fetch(32'h100, 1'b1, w);

        // Simultaneous redirects: priority
        ack_redirect(32'h104, 1'b1, 1'b1, 1'b1, 32'h200, 32'h300);
`ifdef PC_SEQ_EXC_EN
        fetch(32'h180, 1'b1, w);
        ack_redirect(32'h184, 1'b0, 1'b1, 1'b0, 32'h0, 32'h300);
`else
        fetch(32'h200, 1'b1, w);
        ack_redirect(32'h204, 1'b0, 1'b1, 1'b0, 32'h0, 32'h300);
`endif
        fetch(32'h300, 1'b1, w);

        // Misaligned target, then wrap at top of address space
        ack_redirect(32'h304, 1'b1, 1'b0, 1'b0, 32'h103, 32'h0);
        fetch(32'h100, 1'b1, w);
        ack_redirect(32'h104, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0);
        fetch(32'hFFFF_FFFC, 1'b1, w);
        chk("pc_wrap", bus_if.pc, 32'h0);
        fetch(32'h0, 1'b1, w);

        // Redirect in HOLD with stall still high; ack outside REQ ignored
        wait_req(w);
        exp_req_q.push_back(32'h4);
        exp_out_q.push_back(32'h4);
        bus_if.imem_ack = 1'b1;
        bus_if.stall    = 1'b1;
        tick();
        chk("hold2_valid", 32'(bus_if.if_valid), 32'd1);
        bus_if.jmp        = 1'b1;
        bus_if.jmp_target = 32'h500;
        tick();
        bus_if.jmp      = 1'b0;
        bus_if.imem_ack = 1'b0;
        chk("hold_redir_valid", 32'(bus_if.if_valid), 32'd0);
        chk("hold_redir_addr",  bus_if.imem_addr, 32'h500);
        bus_if.stall = 1'b0;
        fetch(32'h500, 1'b1, w);

        // Reset in the middle of a request at 0x40, late ack ignored
        ack_redirect(32'h504, 1'b0, 1'b1, 1'b0, 32'h0, 32'h40);
        wait_req(w);
        chk("pre_rst_addr", bus_if.imem_addr, 32'h40);
        reset = 1'b0;
        #1;
        chk_reset_vals("async");
        bus_if.imem_ack = 1'b1;
        tick();
        chk_reset_vals("rst_ack");
        reset            = 1'b1;
        bus_if.br_taken  = 1'b1;
        bus_if.br_target = 32'h700;
        tick();
        bus_if.imem_ack = 1'b0;
        bus_if.br_taken = 1'b0;
        chk("restart_req",  32'(bus_if.imem_req), 32'd1);
        chk("restart_addr", bus_if.imem_addr, 32'h0);
        fetch(32'h0, 1'b1, w);
        fetch(32'h4, 1'b1, w);
        repeat (3) tick();
        chk("req_q_left", 32'(exp_req_q.size()), 32'd0);
        chk("out_q_left", 32'(exp_out_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
